// File: rtl/instr_prefetch_queue.sv
// instr_prefetch_queue
// Instruction-fetch front end. Owns the fetch PC, issues reads to a synchronous instruction
// memory with one cycle of read latency, buffers returned words in a DEPTH-entry FIFO and hands
// {instr, pc} to the decode stage over a valid/ready handshake. A flush redirects fetch to
// flush_pc. Fetching stops once an END opcode has been returned from memory.
//
// Ports
//   clk         single clock, all state on posedge
//   reset       synchronous, active-high; takes priority over flush
//   imem_req    read strobe to instruction memory
//   imem_addr   read address (current fetch PC)
//   imem_rdata  read data, valid the cycle after imem_req
//   flush       discard queue and any in-flight read, restart fetch at flush_pc
//   flush_pc    new fetch PC used when flush is high
//   out_valid   head entry present on out_instr / out_pc
//   out_ready   consumer accepts the head entry when out_valid is also high
//   out_instr   head instruction (zero when the queue is empty)
//   out_pc      fetch address of the head instruction (zero when the queue is empty)
//   halted      END fetched; no further requests until flush or reset
//   count       current FIFO occupancy
module instr_prefetch_queue #(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned AW         = 10,
  parameter int unsigned DW         = 16,
  parameter logic [3:0]  END_OPCODE = 4'hC
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic                     imem_req,
  output logic [AW-1:0]            imem_addr,
  input  logic [DW-1:0]            imem_rdata,
  input  logic                     flush,
  input  logic [AW-1:0]            flush_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DW-1:0]            out_instr,
  output logic [AW-1:0]            out_pc,
  output logic                     halted,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW:0] DepthLim = (CntW + 1)'(DEPTH);

  typedef enum logic [0:0] {StFetch, StHalt} state_e;

  state_e           state_q;
  logic [AW-1:0]    fetch_pc_q;
  logic [AW-1:0]    req_pc_q;    // address of the read currently in flight
  logic             inflight_q;
  logic [PtrW-1:0]  wr_ptr_q;
  logic [PtrW-1:0]  rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic [DW-1:0]    instr_mem_q [DEPTH];
  logic [AW-1:0]    pc_mem_q    [DEPTH];

  logic             resp_end;
  logic             push;
  logic             pop;
  logic [CntW:0]    credit;

  // Occupancy plus the outstanding read: a request is only issued when its response is
  // guaranteed a free slot, so a push is never dropped.
  always_comb begin
    credit    = {1'b0, count_q} + (CntW + 1)'(inflight_q);
    resp_end  = inflight_q && (imem_rdata[DW-1 -: 4] == END_OPCODE);
    halted    = (state_q == StHalt);
    imem_req  = !reset && !flush && !halted && !resp_end && (credit < DepthLim);
    imem_addr = fetch_pc_q;
    push      = inflight_q && !flush;
    out_valid = (count_q != '0);
    // A handshake in the flush cycle is ignored; the entry is discarded with the rest.
    pop       = out_valid && out_ready && !flush;
    out_instr = out_valid ? instr_mem_q[rd_ptr_q] : '0;
    out_pc    = out_valid ? pc_mem_q[rd_ptr_q] : '0;
    count     = count_q;
  end

  // Fetch FSM, PC, in-flight tracking and FIFO pointers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StFetch;
      fetch_pc_q <= '0;
      req_pc_q   <= '0;
      inflight_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      inflight_q <= imem_req;
      if (imem_req) begin
        fetch_pc_q <= fetch_pc_q + AW'(1);
        req_pc_q   <= fetch_pc_q;
      end
      if (flush) begin
        state_q    <= StFetch;
        fetch_pc_q <= flush_pc;
        wr_ptr_q   <= '0;
        rd_ptr_q   <= '0;
        count_q    <= '0;
      end else begin
        if (resp_end) begin
          state_q <= StHalt;
        end
        if (push) begin
          wr_ptr_q <= wr_ptr_q + PtrW'(1);
        end
        if (pop) begin
          rd_ptr_q <= rd_ptr_q + PtrW'(1);
        end
        count_q <= count_q + CntW'(push) - CntW'(pop);
      end
    end
  end

  // FIFO storage; contents are don't-care outside the valid window, so no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem_q[wr_ptr_q] <= imem_rdata;
      pc_mem_q[wr_ptr_q]    <= req_pc_q;
    end
  end

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Bench for instr_prefetch_queue: synchronous memory model, delivery-order model
// (next expected pc, instruction = mem[pc]) checked every cycle, plus directed scenarios.
module tb_instr_prefetch_queue;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 10;
  localparam int unsigned DW    = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          flush = 1'b0;
  logic [AW-1:0] flush_pc = '0;
  logic          out_ready = 1'b0;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic [DW-1:0] imem_rdata = '0;
  logic          out_valid;
  logic [DW-1:0] out_instr;
  logic [AW-1:0] out_pc;
  logic          halted;
  logic [2:0]    count;

  logic [DW-1:0] mem [1024];

  int checks = 0;
  int failures = 0;

  // Model state: next pc the consumer must receive, and whether END has been delivered.
  logic [AW-1:0] exp_pc = '0;
  logic          end_seen = 1'b0;
  int            deliv_cnt = 0;
  logic          prev_req = 1'b0;

  always #5 clk = ~clk;

  instr_prefetch_queue #(
    .DEPTH(DEPTH), .AW(AW), .DW(DW), .END_OPCODE(4'hC)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .imem_req  (imem_req),
    .imem_addr (imem_addr),
    .imem_rdata(imem_rdata),
    .flush     (flush),
    .flush_pc  (flush_pc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_pc    (out_pc),
    .halted    (halted),
    .count     (count)
  );

  // Synchronous instruction memory, one cycle of latency.
  always @(posedge clk) begin
    if (imem_req) imem_rdata <= mem[imem_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model update from the handshake and control inputs of the cycle just ending.
  always @(posedge clk) begin
    prev_req <= imem_req;
    if (reset) begin
      exp_pc   <= '0;
      end_seen <= 1'b0;
    end else if (flush) begin
      exp_pc   <= flush_pc;
      end_seen <= 1'b0;
    end else if (out_valid && out_ready) begin
      if (mem[exp_pc][15:12] == 4'hC) end_seen <= 1'b1;
      exp_pc    <= exp_pc + 10'd1;
      deliv_cnt <= deliv_cnt + 1;
    end
  end

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    if (!reset) begin
      chk("valid_vs_count", {31'd0, out_valid}, {31'd0, count != 3'd0});
      chk("count_le_depth", {31'd0, count <= DEPTH}, 32'd1);
      if (out_valid) begin
        chk("model_pc", {22'd0, out_pc}, {22'd0, exp_pc});
        chk("model_instr", {16'd0, out_instr}, {16'd0, mem[exp_pc]});
        chk("no_output_after_end", {31'd0, end_seen}, 32'd0);
      end
      if (flush || halted) chk("req_blocked", {31'd0, imem_req}, 32'd0);
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: time limit reached checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  initial begin
    int  nreq;
    bit  got;
    int  base;

    for (int i = 0; i < 1024; i++) mem[i] = 16'(i);

    // Reset values and streaming at one instruction per cycle.
    reset = 1'b1; out_ready = 1'b1;
    next(); next(); neg();
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_count", {29'd0, count}, 32'd0);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_pc", {22'd0, out_pc}, 32'd0);
    chk("rst_instr", {16'd0, out_instr}, 32'd0);
    next(); reset = 1'b0;
    neg();
    chk("t1_req0", {31'd0, imem_req}, 32'd1);
    chk("t1_addr0", {22'd0, imem_addr}, 32'd0);
    next(); neg();
    chk("t1_no_valid_c1", {31'd0, out_valid}, 32'd0);
    for (int k = 2; k < 10; k++) begin
      next(); neg();
      chk("t1_valid", {31'd0, out_valid}, 32'd1);
      chk("t1_pc", {22'd0, out_pc}, k - 2);
      chk("t1_instr", {16'd0, out_instr}, k - 2);
    end

    // Backpressure from reset: exactly four requests, then resume at addr 4.
    next(); reset = 1'b1; out_ready = 1'b0;
    next(); reset = 1'b0;
    nreq = 0;
    for (int c = 0; c < 10; c++) begin
      neg();
      if (imem_req) begin
        chk("t2_req_addr", {22'd0, imem_addr}, nreq);
        nreq++;
      end
      next();
    end
    chk("t2_nreq", nreq, 32'd4);
    neg();
    chk("t2_count_full", {29'd0, count}, 32'd4);
    chk("t2_req_stalled", {31'd0, imem_req}, 32'd0);
    next(); out_ready = 1'b1;
    neg();
    chk("t2_head_pc", {22'd0, out_pc}, 32'd0);
    got = 1'b0;
    for (int c = 0; c < 5 && !got; c++) begin
      next(); neg();
      if (imem_req) begin
        got = 1'b1;
        chk("t2_resume_addr", {22'd0, imem_addr}, 32'd4);
      end
    end
    chk("t2_resume_seen", {31'd0, got}, 32'd1);

    // Flush with three entries queued and a read in flight.
    next(); next(); next(); out_ready = 1'b0;
    got = 1'b0;
    for (int c = 0; c < 8 && !got; c++) begin
      neg();
      if (count == 3'd3) got = 1'b1;
      else next();
    end
    chk("t3_count3_seen", {31'd0, got}, 32'd1);
    chk("t3_inflight", {31'd0, prev_req}, 32'd1);
    #1; flush = 1'b1; flush_pc = 10'h120;
    next(); flush = 1'b0;
    neg();
    chk("t3_count0", {29'd0, count}, 32'd0);
    chk("t3_valid0", {31'd0, out_valid}, 32'd0);
    chk("t3_req", {31'd0, imem_req}, 32'd1);
    chk("t3_addr", {22'd0, imem_addr}, 32'h120);
    next(); neg();
    chk("t3_valid_f2", {31'd0, out_valid}, 32'd0);
    next(); neg();
    chk("t3_valid_f3", {31'd0, out_valid}, 32'd1);
    chk("t3_pc_f3", {22'd0, out_pc}, 32'h120);
    chk("t3_instr_f3", {16'd0, out_instr}, 32'h120);
    next(); out_ready = 1'b1;

    // END opcode at address 5 halts fetch.
    next(); reset = 1'b1; mem[5] = 16'hC000;
    next(); reset = 1'b0; out_ready = 1'b1;
    base = deliv_cnt;
    got = 1'b0;
    for (int c = 0; c < 30 && !got; c++) begin
      neg();
      if (halted) got = 1'b1;
      else next();
    end
    chk("t4_halted", {31'd0, got}, 32'd1);
    for (int c = 0; c < 20; c++) begin
      next(); neg();
      chk("t4_no_req", {31'd0, imem_req}, 32'd0);
      chk("t4_stay_halted", {31'd0, halted}, 32'd1);
    end
    chk("t4_delivered", deliv_cnt - base, 32'd6);
    next(); flush = 1'b1; flush_pc = 10'd0;
    next(); flush = 1'b0;
    neg();
    chk("t4_unhalted", {31'd0, halted}, 32'd0);
    chk("t4_restart_req", {31'd0, imem_req}, 32'd1);
    chk("t4_restart_addr", {22'd0, imem_addr}, 32'd0);

    // PC wrap at the top of the address space.
    next(); flush = 1'b1; flush_pc = 10'd1022;
    next(); flush = 1'b0;
    next(); next();
    for (int i = 0; i < 4; i++) begin
      neg();
      chk("t5_valid", {31'd0, out_valid}, 32'd1);
      chk("t5_pc", {22'd0, out_pc}, (1022 + i) % 1024);
      next();
    end
    got = 1'b0;
    for (int c = 0; c < 40 && !got; c++) begin
      neg();
      if (halted && !out_valid) got = 1'b1;
      else next();
    end
    chk("t5_halted_drained", {31'd0, got}, 32'd1);
    mem[5] = 16'd5;

    // Reset together with flush while entries are queued: reset wins.
    next(); flush = 1'b1; flush_pc = 10'h40;
    next(); flush = 1'b0;
    next(); next(); next(); next(); out_ready = 1'b0;
    got = 1'b0;
    for (int c = 0; c < 8 && !got; c++) begin
      neg();
      if (count == 3'd3) got = 1'b1;
      else next();
    end
    chk("t6_count3_seen", {31'd0, got}, 32'd1);
    #1; reset = 1'b1; flush = 1'b1; flush_pc = 10'h200;
    next(); reset = 1'b0; flush = 1'b0; out_ready = 1'b1;
    neg();
    chk("t6_count", {29'd0, count}, 32'd0);
    chk("t6_valid", {31'd0, out_valid}, 32'd0);
    chk("t6_halted", {31'd0, halted}, 32'd0);
    chk("t6_pc", {22'd0, out_pc}, 32'd0);
    chk("t6_instr", {16'd0, out_instr}, 32'd0);
    chk("t6_req", {31'd0, imem_req}, 32'd1);
    chk("t6_addr", {22'd0, imem_addr}, 32'd0);
    next(); next(); neg();
    chk("t6_first_valid", {31'd0, out_valid}, 32'd1);
    chk("t6_first_pc", {22'd0, out_pc}, 32'd0);
    for (int c = 0; c < 10; c++) next();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
